// File: rtl/fifo_packet_reader_pkg.sv
// Shared types and helpers for the FIFO packet reader and its skid buffer.
package fifo_packet_reader_pkg;

  // Parser state: waiting for a header word, or streaming payload words.
  typedef enum logic [0:0] {
    S_HEADER = 1'b0,
    S_DATA   = 1'b1
  } state_t;

  // Default width of the header byte-length field.
  localparam int LEN_WIDTH_DEFAULT = 16;

  // The length field sits in the low bits of the header word.
  localparam int HDR_LEN_LSB = 0;

  // Widest byte-enable vector the keep helper can produce.
  localparam int KEEP_MAX = 128;

  // Byte enables for a beat carrying 'rem' valid bytes out of 'bytes'.
  // A remainder of zero means the beat is completely filled.
  function automatic logic [KEEP_MAX-1:0] keep_from_rem(input int unsigned rem,
                                                        input int unsigned bytes);
    logic [KEEP_MAX-1:0] keep;
    keep = {KEEP_MAX{1'b0}};
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      if (rem == 32'd0) begin
        keep[i] = (i < bytes);
      end else begin
        keep[i] = (i < rem);
      end
    end
    return keep;
  endfunction

endpackage

// File: rtl/fifo_packet_reader_skid.sv
// Three-entry FIFO-ordered skid buffer. The head (oldest word) is always held
// in entry 0 so it comes straight from a register; push and pop may happen in
// the same cycle. A push into a full buffer is dropped, so callers must only
// push when they have reserved space.
module fifo_skid_buffer
  import fifo_packet_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  head_valid,
  output logic [1:0]            occ
);

  localparam int         DEPTH    = 3;
  localparam logic [1:0] OCC_FULL = 2'd3;

  logic [DATA_WIDTH-1:0] r_mem     [DEPTH];
  logic [DATA_WIDTH-1:0] w_shift   [DEPTH];
  logic [DATA_WIDTH-1:0] w_mem_nxt [DEPTH];
  logic [1:0]            r_occ;
  logic [1:0]            w_occ_after_pop;
  logic [1:0]            w_occ_nxt;
  logic                  w_do_pop;
  logic                  w_push_ok;

  // Next-state of the storage: shift out the head on pop, then append the
  // pushed word behind the remaining entries.
  always_comb begin
    w_do_pop        = pop && (r_occ != 2'd0);
    w_occ_after_pop = w_do_pop ? (r_occ - 2'd1) : r_occ;
    w_push_ok       = push && (w_occ_after_pop != OCC_FULL);
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_shift[i] = w_do_pop ? r_mem[i+1] : r_mem[i];
    end
    w_shift[DEPTH-1] = w_do_pop ? {DATA_WIDTH{1'b0}} : r_mem[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      w_mem_nxt[i] = (w_push_ok && (w_occ_after_pop == 2'(i))) ? push_data : w_shift[i];
    end
    w_occ_nxt = w_occ_after_pop + {1'b0, w_push_ok};
  end

  // Storage and occupancy registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_WIDTH{1'b0}};
      end
      r_occ <= 2'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= w_mem_nxt[i];
      end
      r_occ <= w_occ_nxt;
    end
  end

  assign head       = r_mem[0];
  assign head_valid = (r_occ != 2'd0);
  assign occ        = r_occ;

endmodule

// File: rtl/fifo_packet_reader.sv
// Reads a standard-mode FIFO, absorbs its one-cycle read latency in a skid
// buffer, and splits the word stream into packets (header word carrying the
// byte length, then payload words) presented as a valid/ready stream.
module fifo_packet_reader
  import fifo_packet_reader_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int DATA_COUNT_WIDTH = 1,
  parameter int LEN_WIDTH        = LEN_WIDTH_DEFAULT
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic                        fifo_clock,
  output logic                        fifo_reset,
  input  logic [DATA_WIDTH-1:0]       fifo_rd_data,
  output logic                        fifo_rd_en,
  input  logic                        fifo_empty,
  input  logic                        fifo_almost_empty,
  input  logic [DATA_COUNT_WIDTH-1:0] fifo_rd_data_count,
  output logic [DATA_WIDTH-1:0]       m_tdata,
  output logic [DATA_WIDTH/8-1:0]     m_tkeep,
  output logic                        m_tlast,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [31:0]                 pkt_count,
  output logic                        err_zero_len,
  output logic                        busy
);

  localparam int                   BPW      = DATA_WIDTH / 8;
  localparam int                   BPW_LOG2 = $clog2(BPW);
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] REM_MASK = LEN_WIDTH'(BPW - 1);

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_words_left;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic [31:0]           r_pkt_count;
  logic                  r_err_zero_len;
  logic                  r_inflight;

  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_head_valid;
  logic [1:0]            w_occ;
  logic                  w_pop;
  logic                  w_rd_en;
  logic                  w_last;
  logic [LEN_WIDTH-1:0]  w_len;
  logic [LEN_WIDTH-1:0]  w_rem;
  logic [LEN_WIDTH-1:0]  w_words;
  logic [KEEP_MAX-1:0]   w_keep_full;
  logic [BPW-1:0]        w_keep_last;
  logic                  w_unused;

  assign fifo_clock = clock;
  assign fifo_reset = reset;

  // Level and count hints are not needed: the empty flag plus our own
  // reservation count is enough to pace reads.
  assign w_unused = ^{fifo_almost_empty, fifo_rd_data_count, w_keep_full};

  // Only request a word when the skid buffer is guaranteed to have room for
  // it on arrival, counting the word already in flight. No dependency on
  // m_tready, and no pop while reset is held so no word is lost to reset.
  assign w_rd_en    = !reset && !fifo_empty &&
                      (({1'b0, w_occ} + {2'b00, r_inflight}) <= 3'd2);
  assign fifo_rd_en = w_rd_en;

  fifo_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clock      (clock),
    .reset      (reset),
    .push       (r_inflight),
    .push_data  (fifo_rd_data),
    .pop        (w_pop),
    .head       (w_head),
    .head_valid (w_head_valid),
    .occ        (w_occ)
  );

  // Header decode: byte length, partial-word remainder and word count.
  // The word count uses shift plus a round-up bit so the maximum length
  // cannot overflow the field.
  assign w_len   = w_head[HDR_LEN_LSB +: LEN_WIDTH];
  assign w_rem   = w_len & REM_MASK;
  assign w_words = (w_len >> BPW_LOG2) + ((w_rem != LEN_ZERO) ? LEN_ONE : LEN_ZERO);

  assign w_last      = (r_words_left == LEN_ONE);
  assign w_keep_full = keep_from_rem(32'(r_rem), 32'(BPW));
  assign w_keep_last = w_keep_full[BPW-1:0];

  // Skid pop: headers are consumed as soon as they reach the head, payload
  // words only on a completed stream handshake.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_HEADER: w_pop = w_head_valid;
      S_DATA:   w_pop = w_head_valid && m_tready;
      default:  w_pop = 1'b0;
    endcase
  end

  // Stream outputs come straight from the registered skid head, so they stay
  // stable while a beat is stalled.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = {DATA_WIDTH{1'b0}};
    m_tkeep  = {BPW{1'b0}};
    m_tlast  = 1'b0;
    if (r_state == S_DATA) begin
      m_tvalid = w_head_valid;
      m_tdata  = w_head;
      m_tlast  = w_last;
      if (w_last && (r_rem != LEN_ZERO)) begin
        m_tkeep = w_keep_last;
      end else begin
        m_tkeep = {BPW{1'b1}};
      end
    end else begin
      m_tvalid = 1'b0;
      m_tdata  = {DATA_WIDTH{1'b0}};
      m_tkeep  = {BPW{1'b0}};
      m_tlast  = 1'b0;
    end
  end

  // Packet parser FSM with read-latency tracking and status counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_HEADER;
      r_words_left   <= LEN_ZERO;
      r_rem          <= LEN_ZERO;
      r_pkt_count    <= 32'd0;
      r_err_zero_len <= 1'b0;
      r_inflight     <= 1'b0;
    end else begin
      r_inflight     <= w_rd_en;
      r_err_zero_len <= 1'b0;
      case (r_state)
        S_HEADER: begin
          if (w_head_valid) begin
            if (w_len == LEN_ZERO) begin
              r_err_zero_len <= 1'b1;
            end else begin
              r_words_left <= w_words;
              r_rem        <= w_rem;
              r_state      <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_head_valid && m_tready) begin
            r_words_left <= r_words_left - LEN_ONE;
            if (w_last) begin
              r_pkt_count <= r_pkt_count + 32'd1;
              r_state     <= S_HEADER;
            end
          end
        end
        default: begin
          r_state <= S_HEADER;
        end
      endcase
    end
  end

  assign pkt_count    = r_pkt_count;
  assign err_zero_len = r_err_zero_len;
  assign busy         = (r_state == S_DATA);

endmodule

// File: tb/tb_fifo_packet_reader.sv
// Bench for fifo_packet_reader: FIFO model on the read side, beat monitor on
// the stream side, and a packet-level reference that turns the pushed word
// list into the expected beat list.
module tb_fifo_packet_reader;

  localparam int DW  = 32;
  localparam int BPW = DW / 8;
  localparam int DCW = 1;
  localparam int LW  = 16;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [BPW-1:0] keep;
    logic           last;
  } beat_t;

  logic           clock = 1'b0;
  logic           reset;
  logic           fifo_clock, fifo_reset, fifo_rd_en;
  logic [DW-1:0]  fifo_rd_data;
  logic           fifo_empty, fifo_almost_empty;
  logic [DCW-1:0] fifo_rd_data_count;
  logic [DW-1:0]  m_tdata;
  logic [BPW-1:0] m_tkeep;
  logic           m_tlast, m_tvalid, m_tready;
  logic [31:0]    pkt_count;
  logic           err_zero_len, busy;

  fifo_packet_reader #(
    .DATA_WIDTH       (DW),
    .DATA_COUNT_WIDTH (DCW),
    .LEN_WIDTH        (LW)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .fifo_clock         (fifo_clock),
    .fifo_reset         (fifo_reset),
    .fifo_rd_data       (fifo_rd_data),
    .fifo_rd_en         (fifo_rd_en),
    .fifo_empty         (fifo_empty),
    .fifo_almost_empty  (fifo_almost_empty),
    .fifo_rd_data_count (fifo_rd_data_count),
    .m_tdata            (m_tdata),
    .m_tkeep            (m_tkeep),
    .m_tlast            (m_tlast),
    .m_tvalid           (m_tvalid),
    .m_tready           (m_tready),
    .pkt_count          (pkt_count),
    .err_zero_len       (err_zero_len),
    .busy               (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] stim_q [$];
  beat_t         exp_q  [$];
  beat_t         got_q  [$];
  int            got_cyc [$];
  int            exp_err;
  int            exp_pkts;
  int            err_seen;
  int            cyc_g;
  bit            timed_out;

  logic           s_tvalid, s_tlast, s_rd_en, s_busy, s_err, s_reset, s_fifo_reset;
  logic [DW-1:0]  s_tdata;
  logic [BPW-1:0] s_tkeep;
  logic [31:0]    s_pkt;

  // One clock cycle: sample everything at the falling edge, then model the
  // FIFO read port just after the rising edge.
  task automatic tick();
    beat_t b;
    @(negedge clock);
    s_tvalid = m_tvalid; s_tdata = m_tdata; s_tkeep = m_tkeep; s_tlast = m_tlast;
    s_rd_en = fifo_rd_en; s_busy = busy; s_err = err_zero_len; s_pkt = pkt_count;
    s_reset = reset; s_fifo_reset = fifo_reset;
    if (!reset && m_tvalid && m_tready) begin
      b.data = m_tdata; b.keep = m_tkeep; b.last = m_tlast;
      got_q.push_back(b);
      got_cyc.push_back(cyc_g);
    end
    if (!reset && err_zero_len) err_seen++;
    @(posedge clock);
    #1;
    cyc_g++;
    if (s_reset) begin
      fifo_q.delete();
      fifo_rd_data = '0;
    end else if (s_rd_en && fifo_q.size() > 0) begin
      fifo_rd_data = fifo_q.pop_front();
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  // Reference: walk the word list as header + ceil(len/BPW) payload words.
  task automatic build_expected();
    int idx; int len; int nw; beat_t b; logic [DW-1:0] w;
    exp_q.delete(); exp_err = 0; idx = 0;
    while (idx < stim_q.size()) begin
      w = stim_q[idx]; idx++;
      len = int'(w[LW-1:0]);
      if (len == 0) begin
        exp_err++;
      end else begin
        nw = (len + BPW - 1) / BPW;
        for (int j = 0; j < nw && idx < stim_q.size(); j++) begin
          b.data = stim_q[idx]; idx++;
          b.last = (j == nw - 1);
          b.keep = (b.last && (len % BPW) != 0) ? BPW'((1 << (len % BPW)) - 1) : {BPW{1'b1}};
          exp_q.push_back(b);
        end
        exp_pkts++;
      end
    end
  endtask

  // Push a random packet of the given byte length into stim_q.
  task automatic add_packet(input int len);
    logic [DW-1:0] hdr;
    hdr = $urandom;
    hdr[LW-1:0] = LW'(len);
    stim_q.push_back(hdr);
    for (int j = 0; j < (len + BPW - 1) / BPW; j++) stim_q.push_back($urandom);
  endtask

  // Feed stim_q through the DUT and collect beats until everything settles.
  task automatic run_stream(input int ready_pct, input int push_pct, input bit preload,
                            input int bound);
    int pi; int cyc; int idle;
    build_expected();
    got_q.delete(); got_cyc.delete(); err_seen = 0;
    pi = 0; cyc = 0; idle = 0;
    if (preload) begin
      foreach (stim_q[i]) fifo_q.push_back(stim_q[i]);
      pi = stim_q.size();
      fifo_empty = (fifo_q.size() == 0);
    end
    while (idle < 8 && cyc < bound) begin
      m_tready = ($urandom_range(99) < ready_pct);
      if (pi < stim_q.size() && $urandom_range(99) < push_pct) begin
        fifo_q.push_back(stim_q[pi]); pi++; fifo_empty = 1'b0;
      end
      tick(); cyc++;
      if (pi == stim_q.size() && fifo_q.size() == 0 && got_q.size() >= exp_q.size()) idle++;
      else idle = 0;
    end
    timed_out = (cyc >= bound);
  endtask

  task automatic test_reset();
    reset = 1'b1; m_tready = 1'b0;
    repeat (3) tick();
    checks++; if (s_fifo_reset !== 1'b1) begin errors++; $display("FAIL reset_fifo_reset: got %b want 1", s_fifo_reset); end
    checks++; if (s_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en_in_reset: got %b want 0", s_rd_en); end
    reset = 1'b0;
    tick();
    checks++; if (s_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", s_tvalid); end
    checks++; if (s_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", s_tlast); end
    checks++; if (s_tkeep !== '0) begin errors++; $display("FAIL reset_tkeep: got %h want 0", s_tkeep); end
    checks++; if (s_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", s_tdata); end
    checks++; if (s_pkt !== 32'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d want 0", s_pkt); end
    checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", s_err); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", s_busy); end
    checks++; if (s_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", s_rd_en); end
    exp_pkts = 0;
  endtask

  task automatic test_basic();
    stim_q = '{32'd8, 32'hAAAA0001, 32'hAAAA0002};
    run_stream(100, 100, 1'b1, 100);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got timeout want completion"); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_beats: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (err_seen != 0) begin errors++; $display("FAIL basic_err: got %0d want 0", err_seen); end
    checks++; if (pkt_count !== 32'(exp_pkts)) begin errors++; $display("FAIL basic_pkt_count: got %0d want %0d", pkt_count, exp_pkts); end
  endtask

  task automatic test_partial_keep();
    stim_q = '{32'd5, 32'h11223344, 32'h000000EE};
    run_stream(100, 100, 1'b1, 100);
    checks++; if (timed_out) begin errors++; $display("FAIL keep_timeout: got timeout want completion"); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL keep_beats: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL keep_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pkt_count !== 32'(exp_pkts)) begin errors++; $display("FAIL keep_pkt_count: got %0d want %0d", pkt_count, exp_pkts); end
  endtask

  task automatic test_back_to_back();
    int span;
    stim_q.delete();
    for (int p = 0; p < 10; p++) add_packet(16);
    run_stream(100, 100, 1'b1, 200);
    checks++; if (timed_out) begin errors++; $display("FAIL b2b_timeout: got timeout want completion"); end
    checks++; if (got_q.size() != 40) begin errors++; $display("FAIL b2b_beats: got %0d want 40", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    span = (got_cyc.size() > 0) ? (got_cyc[got_cyc.size()-1] - got_cyc[0] + 1) : 0;
    checks++; if (span != 49) begin errors++; $display("FAIL b2b_throughput: got span %0d cycles want 49", span); end
    checks++; if (pkt_count !== 32'(exp_pkts)) begin errors++; $display("FAIL b2b_pkt_count: got %0d want %0d", pkt_count, exp_pkts); end
  endtask

  task automatic test_stall();
    beat_t hold; beat_t cur; int cyc;
    stim_q.delete(); add_packet(64);
    build_expected(); got_q.delete(); got_cyc.delete(); err_seen = 0;
    foreach (stim_q[i]) fifo_q.push_back(stim_q[i]);
    fifo_empty = 1'b0; m_tready = 1'b1; cyc = 0;
    while (got_q.size() < 4 && cyc < 200) begin tick(); cyc++; end
    m_tready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(); cyc++;
      cur.data = s_tdata; cur.keep = s_tkeep; cur.last = s_tlast;
      checks++; if (s_tvalid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d: got %b want 1", k, s_tvalid); end
      if (k == 0) hold = cur;
      else begin
        checks++; if (cur !== hold) begin errors++; $display("FAIL stall_hold%0d: got %h want %h", k, cur, hold); end
      end
      if (k >= 2) begin
        checks++; if (s_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en%0d: got %b want 0", k, s_rd_en); end
      end
    end
    m_tready = 1'b1;
    while ((got_q.size() < exp_q.size() || fifo_q.size() != 0) && cyc < 400) begin tick(); cyc++; end
    repeat (6) tick();
    checks++; if (cyc >= 400) begin errors++; $display("FAIL stall_timeout: got timeout want completion"); end
    checks++; if (got_q.size() != 16) begin errors++; $display("FAIL stall_beats: got %0d want 16", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pkt_count !== 32'(exp_pkts)) begin errors++; $display("FAIL stall_pkt_count: got %0d want %0d", pkt_count, exp_pkts); end
  endtask

  task automatic test_zero_len();
    stim_q = '{32'd0, 32'd4, 32'hDEADBEEF};
    run_stream(100, 100, 1'b1, 100);
    checks++; if (timed_out) begin errors++; $display("FAIL zero_timeout: got timeout want completion"); end
    checks++; if (err_seen != 1) begin errors++; $display("FAIL zero_err_pulses: got %0d want 1", err_seen); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL zero_beats: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL zero_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pkt_count !== 32'(exp_pkts)) begin errors++; $display("FAIL zero_pkt_count: got %0d want %0d", pkt_count, exp_pkts); end
  endtask

  task automatic test_reset_mid_packet();
    int cyc;
    stim_q.delete(); add_packet(32);
    got_q.delete(); got_cyc.delete();
    foreach (stim_q[i]) fifo_q.push_back(stim_q[i]);
    fifo_empty = 1'b0; m_tready = 1'b1; cyc = 0;
    while (got_q.size() < 2 && cyc < 100) begin tick(); cyc++; end
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL rst_mid_prefix: got %0d beats want 2", got_q.size()); end
    reset = 1'b1;
    tick();
    checks++; if (s_rd_en !== 1'b0) begin errors++; $display("FAIL rst_mid_rd_en: got %b want 0", s_rd_en); end
    reset = 1'b0; exp_pkts = 0;
    tick();
    checks++; if (s_tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_tvalid: got %b want 0", s_tvalid); end
    checks++; if (s_pkt !== 32'd0) begin errors++; $display("FAIL rst_mid_pkt_count: got %0d want 0", s_pkt); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", s_busy); end
    stim_q = '{32'd4, 32'hCAFEF00D};
    run_stream(100, 100, 1'b1, 100);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rst_mid_beats: got %0d want 1", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_mid_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL rst_mid_pkt_after: got %0d want 1", pkt_count); end
  endtask

  task automatic test_random();
    stim_q.delete();
    for (int p = 0; p < 30; p++) add_packet(($urandom_range(5) == 0) ? 0 : int'($urandom_range(1, 40)));
    run_stream(60, 70, 1'b0, 6000);
    checks++; if (timed_out) begin errors++; $display("FAIL rand_timeout: got timeout want completion"); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_beats: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (err_seen != exp_err) begin errors++; $display("FAIL rand_err_pulses: got %0d want %0d", err_seen, exp_err); end
    checks++; if (pkt_count !== 32'(exp_pkts)) begin errors++; $display("FAIL rand_pkt_count: got %0d want %0d", pkt_count, exp_pkts); end
  endtask

  task automatic test_max_len();
    stim_q.delete(); add_packet(65535);
    run_stream(100, 100, 1'b1, 17000);
    checks++; if (timed_out) begin errors++; $display("FAIL maxlen_timeout: got timeout want completion"); end
    checks++; if (got_q.size() != 16384) begin errors++; $display("FAIL maxlen_beats: got %0d want 16384", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL maxlen_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pkt_count !== 32'(exp_pkts)) begin errors++; $display("FAIL maxlen_pkt_count: got %0d want %0d", pkt_count, exp_pkts); end
  endtask

  initial begin
    reset = 1'b1; m_tready = 1'b0; fifo_rd_data = '0; fifo_empty = 1'b1;
    fifo_almost_empty = 1'b0; fifo_rd_data_count = '0;
    cyc_g = 0; exp_pkts = 0; err_seen = 0; timed_out = 1'b0;
    test_reset();
    test_basic();
    test_partial_keep();
    test_back_to_back();
    test_stall();
    test_zero_len();
    test_reset_mid_packet();
    test_random();
    test_max_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
